// File: rtl/rt_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register writeback countdowns
// drive RAW/WAW/WB-port stalls and WB bypass selects.
module rt_hazard_scoreboard #(
  parameter int S_REGS     = 32,
  parameter int V_REGS     = 16,
  parameter int MAX_LAT    = 7,
  parameter int S_ZERO_REG = 1,
  localparam int S_AW  = $clog2(S_REGS),
  localparam int V_AW  = $clog2(V_REGS),
  localparam int LAT_W = $clog2(MAX_LAT + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de_valid,
  input  logic             pipe_hold,
  input  logic             flush,
  input  logic [S_AW-1:0]  de_s1_addr,
  input  logic [S_AW-1:0]  de_s2_addr,
  input  logic             de_s1_used,
  input  logic             de_s2_used,
  input  logic [V_AW-1:0]  de_v1_addr,
  input  logic [V_AW-1:0]  de_v2_addr,
  input  logic             de_v1_used,
  input  logic             de_v2_used,
  input  logic             de_swb_en,
  input  logic [S_AW-1:0]  de_swb_addr,
  input  logic             de_vwb_en,
  input  logic [V_AW-1:0]  de_vwb_addr,
  input  logic [LAT_W-1:0] de_lat,
  output logic             de_stall,
  output logic             de_s1_sel,
  output logic             de_s2_sel,
  output logic             de_v1_sel,
  output logic             de_v2_sel,
  output logic             sb_empty
);

  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);

  logic [LAT_W-1:0] cnt_s_q [S_REGS];
  logic [LAT_W-1:0] cnt_s_d [S_REGS];
  logic [LAT_W-1:0] cnt_v_q [V_REGS];
  logic [LAT_W-1:0] cnt_v_d [V_REGS];

  function automatic logic s_trk(input logic [S_AW-1:0] a);
    return !((S_ZERO_REG != 0) && (a == '0));
  endfunction

  logic             s1_live, s2_live;
  logic [LAT_W-1:0] s1_c, s2_c, v1_c, v2_c;
  logic             raw;
  logic             s_wr, v_wr;
  logic             s_waw, v_waw;
  logic             s_port, v_port;
  logic [LAT_W:0]   lat_p1;
  logic             issue;
  logic             pend;

  assign s1_live = de_s1_used & s_trk(de_s1_addr);
  assign s2_live = de_s2_used & s_trk(de_s2_addr);
  assign s1_c    = cnt_s_q[de_s1_addr];
  assign s2_c    = cnt_s_q[de_s2_addr];
  assign v1_c    = cnt_v_q[de_v1_addr];
  assign v2_c    = cnt_v_q[de_v2_addr];

  assign de_s1_sel = s1_live & (s1_c == ONE);
  assign de_s2_sel = s2_live & (s2_c == ONE);
  assign de_v1_sel = de_v1_used & (v1_c == ONE);
  assign de_v2_sel = de_v2_used & (v2_c == ONE);

  assign raw = (s1_live & (s1_c > ONE))
             | (s2_live & (s2_c > ONE))
             | (de_v1_used & (v1_c > ONE))
             | (de_v2_used & (v2_c > ONE));

  assign s_wr   = de_swb_en & s_trk(de_swb_addr);
  assign v_wr   = de_vwb_en;
  assign s_waw  = s_wr & (cnt_s_q[de_swb_addr] > de_lat);
  assign v_waw  = v_wr & (cnt_v_q[de_vwb_addr] > de_lat);
  assign lat_p1 = {1'b0, de_lat} + (LAT_W+1)'(1);

  // An entry at L+1 reaches WB in the same cycle as a new write of latency L.
  always_comb begin
    s_port = 1'b0;
    v_port = 1'b0;
    pend   = 1'b0;
    for (int r = 0; r < S_REGS; r++) begin
      if (S_AW'(r) != de_swb_addr && {1'b0, cnt_s_q[r]} == lat_p1)
        s_port = 1'b1;
      if (cnt_s_q[r] != '0)
        pend = 1'b1;
    end
    for (int r = 0; r < V_REGS; r++) begin
      if (V_AW'(r) != de_vwb_addr && {1'b0, cnt_v_q[r]} == lat_p1)
        v_port = 1'b1;
      if (cnt_v_q[r] != '0)
        pend = 1'b1;
    end
  end

  assign sb_empty = ~pend;
  assign de_stall = de_valid & (raw | s_waw | v_waw
                  | (s_wr & s_port) | (v_wr & v_port));
  assign issue    = de_valid & ~de_stall & ~pipe_hold & ~flush;

  always_comb begin
    for (int r = 0; r < S_REGS; r++) begin
      cnt_s_d[r] = cnt_s_q[r];
      if (!pipe_hold && cnt_s_q[r] != '0)
        cnt_s_d[r] = cnt_s_q[r] - ONE;
      if (issue && s_wr && de_swb_addr == S_AW'(r))
        cnt_s_d[r] = de_lat;
      if (flush)
        cnt_s_d[r] = '0;
    end
    for (int r = 0; r < V_REGS; r++) begin
      cnt_v_d[r] = cnt_v_q[r];
      if (!pipe_hold && cnt_v_q[r] != '0)
        cnt_v_d[r] = cnt_v_q[r] - ONE;
      if (issue && v_wr && de_vwb_addr == V_AW'(r))
        cnt_v_d[r] = de_lat;
      if (flush)
        cnt_v_d[r] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < S_REGS; r++) cnt_s_q[r] <= '0;
      for (int r = 0; r < V_REGS; r++) cnt_v_q[r] <= '0;
    end else begin
      for (int r = 0; r < S_REGS; r++) cnt_s_q[r] <= cnt_s_d[r];
      for (int r = 0; r < V_REGS; r++) cnt_v_q[r] <= cnt_v_d[r];
    end
  end

endmodule

// File: doc/rt_hazard_scoreboard.md
# rt_hazard_scoreboard

Parametrised decode-stage hazard unit for the RT core. Successor to the fixed two-stage forwarding/stall logic: it tracks every in-flight scalar and vector register write with a per-register latency countdown. From that state it drives stall and bypass-select for the instruction in decode. It supports variable writeback latency (ALU, memory read, vector reduce, future long ops), WAW ordering, a single writeback port per register file, pipeline hold and flush.

## Interface
Parameters:
- S_REGS, 32, scalar register count; S_AW = $clog2(S_REGS) (derived)
- V_REGS, 16, vector register count; V_AW = $clog2(V_REGS) (derived)
- MAX_LAT, 7, largest issue-to-writeback latency in cycles; LAT_W = $clog2(MAX_LAT+2) (derived)
- S_ZERO_REG, 1, 1 = scalar register 0 is hardwired zero (never tracked, never stalls or forwards)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- de_valid  in  1  decode holds a valid instruction
- pipe_hold  in  1  back-end stalled; no issue, counters frozen
- flush  in  1  squash all in-flight writes
- de_s1_addr, de_s2_addr  in  S_AW  scalar source addresses
- de_s1_used, de_s2_used  in  1  scalar source actually read
- de_v1_addr, de_v2_addr  in  V_AW  vector source addresses
- de_v1_used, de_v2_used  in  1  vector source actually read
- de_swb_en  in  1  instruction writes a scalar register
- de_swb_addr  in  S_AW  scalar destination
- de_vwb_en  in  1  instruction writes a vector register
- de_vwb_addr  in  V_AW  vector destination
- de_lat  in  LAT_W  writeback latency for this instruction, 1..MAX_LAT
- de_stall  out  1  hold decode
- de_s1_sel, de_s2_sel, de_v1_sel, de_v2_sel  out  1  0 = register file, 1 = WB bypass
- sb_empty  out  1  no tracked write pending

## Operation
- State: cnt_s[r] (S_REGS entries) and cnt_v[r] (V_REGS entries), each LAT_W bits. 0 = not pending. cnt == 1 means the result is on the WB bus this cycle and is written to the register file at the clock edge.
- Issue condition: issue = de_valid & ~de_stall & ~pipe_hold & ~flush.
- On issue with de_swb_en (and not addr 0 when S_ZERO_REG): cnt_s[de_swb_addr] <= de_lat. Vector destinations use the same rule.
- Every other non-zero entry decrements by 1 per cycle unless pipe_hold. When pipe_hold is set, all counters hold.
- flush: all counters <= 0 next cycle. flush wins over issue and hold.
- Per used source with entry count c:
  - c == 0: sel = 0.
  - c == 1: sel = 1, no stall.
  - c > 1: RAW stall.
  - Unused sources never stall and read sel = 0.
- WAW stall: destination entry c > de_lat. The older write must complete first; c <= de_lat is allowed.
- WB-port stall: any other scalar entry == de_lat+1 (two scalar writebacks in the same cycle). Vector file uses the same rule.
- de_stall = de_valid & (any RAW | WAW | WB-port condition). Purely combinational on current state and decode inputs. Independent of pipe_hold.
- The decode instruction's own destination is never compared against its own sources.
- sb_empty = all counters zero.

## Timing
- Reset (async): all counters 0. de_stall 0, all sel 0, sb_empty 1.
- Issue at edge t with de_lat = L: entry reads L during cycle t+1. Data is on WB (entry == 1) in cycle t+L. Entry is 0 from t+L+1.
- Back-to-back dependent instruction, L = 1: no stall, sel = 1.
- Back-to-back dependent instruction, L = 3: stalls 2 cycles, then issues with sel = 1.
- Each cycle of pipe_hold extends every pending latency by 1.
- Reissue to the same register while its entry == 1: new value L loaded; the old write completes normally.
- Reset mid-operation clears all tracking immediately. No stale forward is possible after reset deassert.

## Test plan
- Reset, then issue s5 with L = 1, then a consumer reading s5 as s1 -> no stall, de_s1_sel = 1 in the consumer cycle, sb_empty returns to 1 after 1 cycle.
- Memory load to v3, L = 3, followed by a consumer of v3 as v2 -> de_stall high for exactly 2 cycles, then de_v2_sel = 1 and issue.
- Write s7 with L = 5, then write s7 with L = 2 -> WAW stall until the entry is <= 2. The second write then issues and its result is the one forwarded.
- s2 pending with entry 3, new instruction writing s9 with L = 2 -> WB-port stall for 1 cycle. Same case with L = 3 -> no stall.
- s4 pending with entry 4, pipe_hold high for 3 cycles -> entry stays 4 and de_stall stays high. Then flush -> entries 0, de_stall 0, sb_empty 1 next cycle.
- Issue writing s0 with L = 4 (S_ZERO_REG = 1), consumer reading s0 -> no stall, sel 0, sb_empty stays 1. Assert rst mid-countdown -> all outputs at reset values asynchronously.
